mem_wb_skid_reg: RTL and testbench
==================================

# mem_wb_skid_reg

Parametrised MEM/WB pipeline register with a valid/ready handshake and a one-entry skid buffer. It carries the memory-read flag, writeback enable, destination register, memory read data and ALU result from the MEM stage to WB. It replaces hold-on-SRAM-busy behaviour with a registered back-pressure path, so neither stage has a combinational ready path through it. It also supports a synchronous flush and presents the final writeback value pre-selected.

## Interface
- DATA_W, 32, width of memory data, ALU result and writeback value
- REG_ADDR_W, 4, destination register index width
- STALL_CNT_W, 16, stall counter width (used only with MEM_WB_STALL_CNT_EN)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  synchronous; discards all held entries
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  entry accepted this edge when in_valid & in_ready
- in_mem_read  in  1  entry is a load
- in_wb_en  in  1  entry writes the register file
- in_dest  in  REG_ADDR_W  destination register
- in_mem_data  in  DATA_W  SRAM read data
- in_alu_result  in  DATA_W  ALU result / address
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB consumes the entry this edge when out_valid & out_ready
- out_mem_read, out_wb_en, out_dest, out_mem_data, out_alu_result  out  as inputs  held entry fields
- out_wb_value  out  DATA_W  out_mem_read ? out_mem_data : out_alu_result
- out_wb_commit  out  1  out_valid & out_ready & out_wb_en
- stall_count  out  STALL_CNT_W  present only with MEM_WB_STALL_CNT_EN

## Operation
- Two storage slots: main (drives outputs) and skid. The occupancy FSM has three states:
  - EMPTY: no entry held.
  - ONE: main holds an entry.
  - FULL: main and skid both hold entries.
- in_ready = (state != FULL), driven from the state register only.
- out_valid = (state != EMPTY).
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- EMPTY: on accept, load main and go to ONE.
- ONE:
  - accept & consume: load main, stay in ONE.
  - accept only: load skid, go to FULL.
  - consume only: go to EMPTY.
- FULL:
  - consume: main <= skid, go to ONE.
  - Accept cannot occur in FULL.
- Entries leave in arrival order. No entry is dropped or duplicated.
- flush overrides all other events:
  - next state is EMPTY and an accept in the same cycle is discarded;
  - the data fields keep their values, and only the valid state clears.
- out_wb_value and out_wb_commit are combinational from main and out_ready.
- Data payload registers load only on accept or skid move. They carry no reset, except main, which resets to zero.

## Timing
- Reset (reset=0), asynchronous, sets:
  - state = EMPTY, out_valid = 0, in_ready = 1;
  - every out_* field = 0, out_wb_value = 0, out_wb_commit = 0;
  - stall_count = 0.
- Latency: an entry accepted at edge N is on out_* from after edge N. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle while out_ready stays high.
- out_ready dropping for K cycles: at most one further entry is accepted (into skid). in_ready falls the cycle after the skid fills and rises the cycle after the first consume.
- out_* fields are stable while out_valid & !out_ready.
- Reset deasserting mid-stream: behaves as EMPTY from the first edge after release.

## Configuration
- MEM_WB_STALL_CNT_EN defined:
  - stall_count increments on every edge with out_valid & !out_ready, saturating at all-ones;
  - it clears on reset only (flush does not clear it).
- Undefined: the port and the counter logic are absent, and the block's behaviour is otherwise identical.

## Structure
- The shared pipeline package holds:
  - the MEM/WB payload field layout (mem_read, wb_en, dest, mem_data, alu_result);
  - the occupancy state encoding constants (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - default DATA_W and REG_ADDR_W.
- One sub-module, pipe_skid_slot, is natural: it is a payload register with a load enable and an optional reset, instanced twice (main, skid).

## Test plan
- Reset: hold reset=0 with in_valid=1 -> in_ready=1, out_valid=0, all outputs 0. After release, the first accepted entry appears one cycle later.
- Streaming, with out_ready=1: send loads dest=3, mem_data=0xDEADBEEF, alu=0x40, then an ALU op dest=5, alu=0x1234 -> out_wb_value=0xDEADBEEF then 0x1234 on consecutive cycles, and out_wb_commit=1 on both.
- Back-pressure: drop out_ready for 4 cycles while streaming A,B,C -> A is held, B goes to skid, in_ready goes low, and C is held upstream. On release, A, B, C exit in order with no loss.
- Flush in FULL with simultaneous in_valid -> next cycle out_valid=0 and in_ready=1, and the flushed and offered entries never appear.
- Writeback gating: send an entry with wb_en=0 and out_ready=1 -> out_valid=1 and out_wb_commit=0.
- With MEM_WB_STALL_CNT_EN and STALL_CNT_W=2: stall 5 cycles -> stall_count=3 (saturated). Pulse reset -> 0.

Source files
------------

// File: rtl/mem_wb_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg_pkg
// Shared pipeline definitions for the MEM/WB register:
//   - default payload widths (DEF_DATA_W, DEF_REG_ADDR_W)
//   - occupancy state encoding (OCC_EMPTY / OCC_ONE / OCC_FULL)
//   - MEM/WB payload field layout, MSB first:
//       {mem_read, wb_en, dest, mem_data, alu_result}
//     mem_wb_payload_t documents the layout at the default widths, and
//     payload_w() gives the packed width for any parameterisation.
// -----------------------------------------------------------------------------
package mem_wb_skid_reg_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 4;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic                      mem_read;
        logic                      wb_en;
        logic [DEF_REG_ADDR_W-1:0] dest;
        logic [DEF_DATA_W-1:0]     mem_data;
        logic [DEF_DATA_W-1:0]     alu_result;
    } mem_wb_payload_t;

    function automatic int payload_w(input int data_w, input int reg_addr_w);
        return 2 + reg_addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/mem_wb_skid_reg_pipe_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
// One payload register with a load enable. HAS_RESET selects whether the
// register clears to zero on the asynchronous active-low reset or carries no
// reset at all.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (ignored when HAS_RESET = 0)
//   load   in   capture d on this edge
//   d      in   W-bit payload
//   q      out  W-bit held payload
// -----------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int W         = 8,
    parameter bit HAS_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (HAS_RESET) begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (load) begin
                    q <= d;
                end
            end
        end else begin : g_norst
            logic unused_rst;
            assign unused_rst = rst_n;

            always_ff @(posedge clk) begin
                if (load) begin
                    q <= d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_reg
// MEM/WB pipeline register with valid/ready handshake and a one-entry skid
// buffer. in_ready comes straight from the state register, so there is no
// combinational ready path from WB back to MEM.
// Optional feature macro: MEM_WB_STALL_CNT_EN adds the stall_count port, a
// saturating count of edges with out_valid & !out_ready (cleared by reset only).
// Ports:
//   clk, reset (async, active-low), flush (sync, drops all held entries)
//   in_valid / in_ready, in_mem_read, in_wb_en, in_dest, in_mem_data,
//   in_alu_result                                  - MEM-side entry
//   out_valid / out_ready, out_mem_read, out_wb_en, out_dest, out_mem_data,
//   out_alu_result                                 - WB-side entry
//   out_wb_value   selected writeback data (load data or ALU result)
//   out_wb_commit  entry is consumed this edge and writes the register file
//   stall_count    (MEM_WB_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module mem_wb_skid_reg
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mem_read,
    input  logic                  in_wb_en,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_alu_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mem_read,
    output logic                  out_wb_en,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_wb_value,
    output logic                  out_wb_commit
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    localparam int PW = payload_w(DATA_W, REG_ADDR_W);

    logic [1:0]    state_q, state_d;
    logic          accept, consume;
    logic          main_load, skid_load, skid_move;
    logic [PW-1:0] in_payload, main_d, main_q, skid_q;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // ---------------- occupancy FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- occupancy FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: if (accept) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (accept && !consume) begin
                        state_d = OCC_FULL;
                    end else if (!accept && consume) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL:  if (consume) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase
        end
    end

    // ---------------- occupancy FSM: outputs / load enables ----------------
    // Load enables use in_valid/out_ready with the state directly (in FULL no
    // accept is possible, in EMPTY no consume is possible). Flush suppresses
    // every load so the held data survives and only occupancy clears.
    always_comb begin
        in_ready  = (state_q != OCC_FULL);
        out_valid = (state_q != OCC_EMPTY);
        main_load = 1'b0;
        skid_load = 1'b0;
        skid_move = 1'b0;
        if (!flush) begin
            case (state_q)
                OCC_EMPTY: main_load = in_valid;
                OCC_ONE: begin
                    if (in_valid && out_ready) begin
                        main_load = 1'b1;
                    end else if (in_valid) begin
                        skid_load = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (out_ready) begin
                        main_load = 1'b1;
                        skid_move = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- payload slots ----------------
    assign in_payload = {in_mem_read, in_wb_en, in_dest, in_mem_data, in_alu_result};
    assign main_d     = skid_move ? skid_q : in_payload;

    pipe_skid_slot #(.W(PW), .HAS_RESET(1'b1)) u_main (
        .clk   (clk),
        .rst_n (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_skid_slot #(.W(PW), .HAS_RESET(1'b0)) u_skid (
        .clk   (clk),
        .rst_n (reset),
        .load  (skid_load),
        .d     (in_payload),
        .q     (skid_q)
    );

    assign {out_mem_read, out_wb_en, out_dest, out_mem_data, out_alu_result} = main_q;
    assign out_wb_value  = out_mem_read ? out_mem_data : out_alu_result;
    assign out_wb_commit = out_valid & out_ready & out_wb_en;

    // ---------------- optional stall counter ----------------
`ifdef MEM_WB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    logic unused_stall_cfg;
    assign unused_stall_cfg = (STALL_CNT_W > 0);
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_skid_reg
// Bench for mem_wb_skid_reg. A two-deep in-order queue models the register;
// a compare process checks the DUT against it on every falling edge, and
// directed sequences add literal expectations. Build with
// +define+MEM_WB_STALL_CNT_EN to also check the stall counter.
// -----------------------------------------------------------------------------
module tb_mem_wb_skid_reg;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_mem_read = 1'b0;
    logic          in_wb_en = 1'b0;
    logic [AW-1:0] in_dest = '0;
    logic [DW-1:0] in_mem_data = '0;
    logic [DW-1:0] in_alu_result = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, out_mem_read, out_wb_en, out_wb_commit;
    logic [AW-1:0] out_dest;
    logic [DW-1:0] out_mem_data, out_alu_result, out_wb_value;
`ifdef MEM_WB_STALL_CNT_EN
    logic [SW-1:0] stall_count;
`endif

    always #5 clk = ~clk;

    mem_wb_skid_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .STALL_CNT_W(SW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_read    (in_mem_read),
        .in_wb_en       (in_wb_en),
        .in_dest        (in_dest),
        .in_mem_data    (in_mem_data),
        .in_alu_result  (in_alu_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mem_read   (out_mem_read),
        .out_wb_en      (out_wb_en),
        .out_dest       (out_dest),
        .out_mem_data   (out_mem_data),
        .out_alu_result (out_alu_result),
        .out_wb_value   (out_wb_value),
        .out_wb_commit  (out_wb_commit)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    typedef struct {
        logic          mr;
        logic          we;
        logic [AW-1:0] dest;
        logic [DW-1:0] md;
        logic [DW-1:0] alu;
    } ent_t;

    ent_t model_q[$];
    int   stall_m = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue holding at most two entries.
    initial begin : model
        ent_t e;
        bit   acc, con;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_q.delete();
                stall_m = 0;
            end else begin
                acc = in_valid && (model_q.size() < 2);
                con = (model_q.size() > 0) && out_ready;
                if ((model_q.size() > 0) && !out_ready && (stall_m < (1 << SW) - 1))
                    stall_m++;
                if (flush) begin
                    model_q.delete();
                end else begin
                    if (con) void'(model_q.pop_front());
                    if (acc) begin
                        e.mr   = in_mem_read;
                        e.we   = in_wb_en;
                        e.dest = in_dest;
                        e.md   = in_mem_data;
                        e.alu  = in_alu_result;
                        model_q.push_back(e);
                    end
                end
            end
        end
    end

    // Compare process: every falling edge.
    initial begin : compare
        logic [DW-1:0] exp_val;
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, model_q.size() != 0);
            chk("in_ready", in_ready, model_q.size() < 2);
            if (!reset) begin
                chk("rst_dest", out_dest, 0);
                chk("rst_wb_value", out_wb_value, 0);
                chk("rst_flags", {out_mem_read, out_wb_en, out_wb_commit}, 0);
                chk("rst_alu", out_alu_result, 0);
                chk("rst_mem_data", out_mem_data, 0);
            end else if (model_q.size() > 0) begin
                exp_val = model_q[0].mr ? model_q[0].md : model_q[0].alu;
                chk("mem_read", out_mem_read, model_q[0].mr);
                chk("wb_en", out_wb_en, model_q[0].we);
                chk("dest", out_dest, model_q[0].dest);
                chk("mem_data", out_mem_data, model_q[0].md);
                chk("alu_result", out_alu_result, model_q[0].alu);
                chk("wb_value", out_wb_value, exp_val);
                chk("wb_commit", out_wb_commit, out_ready && model_q[0].we);
            end else begin
                chk("wb_commit_idle", out_wb_commit, 0);
            end
`ifdef MEM_WB_STALL_CNT_EN
            chk("stall_count", stall_count, stall_m);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic mr, input logic we,
                         input logic [AW-1:0] d, input logic [DW-1:0] md,
                         input logic [DW-1:0] alu);
        in_valid      = v;
        in_mem_read   = mr;
        in_wb_en      = we;
        in_dest       = d;
        in_mem_data   = md;
        in_alu_result = alu;
    endtask

    initial begin : stim
        // Reset held with an entry offered.
        out_ready = 1'b1;
        offer(1'b1, 1'b1, 1'b1, 4'd9, 32'h1111_2222, 32'h3333_4444);
        repeat (3) step();
        chk("lit_rst_in_ready", in_ready, 1);
        chk("lit_rst_out_valid", out_valid, 0);
        chk("lit_rst_wb_value", out_wb_value, 0);
        chk("lit_rst_dest", out_dest, 0);

        // Release; first entry visible one cycle later.
        reset = 1'b1;
        offer(1'b1, 1'b0, 1'b1, 4'd7, 32'h0, 32'h55);
        step();
        chk("lit_first_valid", out_valid, 1);
        chk("lit_first_value", out_wb_value, 32'h55);

        // Streaming: load then ALU op.
        offer(1'b1, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'h40);
        step();
        chk("lit_stream_load", out_wb_value, 32'hDEAD_BEEF);
        chk("lit_stream_commit0", out_wb_commit, 1);
        offer(1'b1, 1'b0, 1'b1, 4'd5, 32'h0BAD, 32'h1234);
        step();
        chk("lit_stream_alu", out_wb_value, 32'h1234);
        chk("lit_stream_commit1", out_wb_commit, 1);
        in_valid = 1'b0;
        step();
        chk("lit_stream_drain", out_valid, 0);

        // Back-pressure: out_ready low for 4 edges while A, B, C offered.
        out_ready = 1'b0;
        offer(1'b1, 1'b0, 1'b1, 4'd1, 32'h0, 32'hA);
        step();
        chk("lit_bp_ready_a", in_ready, 1);
        offer(1'b1, 1'b0, 1'b1, 4'd2, 32'h0, 32'hB);
        step();
        chk("lit_bp_ready_full", in_ready, 0);
        chk("lit_bp_hold_a", out_dest, 1);
        offer(1'b1, 1'b0, 1'b1, 4'd3, 32'h0, 32'hC);
        step();
        chk("lit_bp_hold_a2", out_alu_result, 32'hA);
        step();
        chk("lit_bp_hold_a3", out_dest, 1);
        out_ready = 1'b1;
        step();
        chk("lit_bp_b", out_dest, 2);
        chk("lit_bp_ready_back", in_ready, 1);
        step();
        chk("lit_bp_c", out_dest, 3);
        in_valid = 1'b0;
        step();
        chk("lit_bp_empty", out_valid, 0);

        // Flush while FULL with an entry offered.
        out_ready = 1'b0;
        offer(1'b1, 1'b0, 1'b1, 4'd8, 32'h0, 32'h80);
        step();
        offer(1'b1, 1'b0, 1'b1, 4'd9, 32'h0, 32'h90);
        step();
        chk("lit_fl_full", in_ready, 0);
        flush = 1'b1;
        offer(1'b1, 1'b0, 1'b1, 4'd10, 32'h0, 32'hA0);
        step();
        chk("lit_fl_valid", out_valid, 0);
        chk("lit_fl_ready", in_ready, 1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("lit_fl_gone", out_valid, 0);

        // Writeback gating.
        offer(1'b1, 1'b0, 1'b0, 4'd4, 32'h0, 32'h77);
        step();
        chk("lit_gate_valid", out_valid, 1);
        chk("lit_gate_commit", out_wb_commit, 0);
        in_valid = 1'b0;
        step();

        // Stall for 5 edges, then reset pulse.
        out_ready = 1'b0;
        offer(1'b1, 1'b0, 1'b1, 4'd6, 32'h0, 32'h66);
        step();
        in_valid = 1'b0;
        repeat (5) step();
`ifdef MEM_WB_STALL_CNT_EN
        chk("lit_stall_sat", stall_count, 3);
`endif
        reset = 1'b0;
        #1;
        chk("lit_async_rst_valid", out_valid, 0);
`ifdef MEM_WB_STALL_CNT_EN
        chk("lit_stall_rst", stall_count, 0);
`endif
        #1;
        reset = 1'b1;
        step();

        // Randomized traffic with a mid-stream asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            offer($urandom_range(0, 99) < 60, 1'(($urandom() & 1)), 1'(($urandom() & 1)),
                  AW'($urandom()), $urandom(), $urandom());
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            if (i == 1500) begin
                #2;
                reset = 1'b0;
                #1;
                chk("lit_mid_rst_valid", out_valid, 0);
                chk("lit_mid_rst_value", out_wb_value, 0);
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("lit_final_empty", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
